// File: rtl/otf_convert_hd.sv
// ----------------------------------------------------------------------------
// otf_convert_hd
// On-the-fly converter: turns a stream of signed online quotient digits
// {-1, 0, +1} into a two's-complement result without carry propagation,
// keeping Q and QM = Q - 1 and selecting between them on every digit.
//
// Ports
//   clk           : clock, rising edge
//   asyn_reset_n  : asynchronous active-low reset
//   digit_in      : 2'b00 = 0, 2'b01 = +1, 2'b10 = -1, 2'b11 = invalid
//   digit_vld     : upstream digit valid
//   digit_rdy     : ready back to upstream (1 while accumulating)
//   result        : NUM_DIGITS+1 bit two's-complement quotient (always = Q)
//   result_vld    : result valid (DONE state)
//   result_rdy    : downstream ready
//   err_flag      : sticky invalid-digit flag (only with OTF_DIGIT_ERR_EN)
//   digit_cnt     : digits accepted in the current frame
//
// Build option
//   OTF_DIGIT_ERR_EN : when defined, accepting digit 2'b11 sets err_flag
//                      until the next result handshake; otherwise err_flag
//                      is tied low. Conversion is identical in both builds.
// ----------------------------------------------------------------------------
module otf_convert_hd #(
    parameter int unsigned NUM_DIGITS = 8
) (
    input  logic                                  clk,
    input  logic                                  asyn_reset_n,
    input  logic [1:0]                            digit_in,
    input  logic                                  digit_vld,
    output logic                                  digit_rdy,
    output logic [NUM_DIGITS:0]                   result,
    output logic                                  result_vld,
    input  logic                                  result_rdy,
    output logic                                  err_flag,
    output logic [$clog2(NUM_DIGITS+1)-1:0]       digit_cnt
);

    localparam int unsigned W  = NUM_DIGITS + 1;
    localparam int unsigned CW = $clog2(NUM_DIGITS + 1);

    localparam logic [1:0] DIG_POS = 2'b01;
    localparam logic [1:0] DIG_NEG = 2'b10;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    q_q, q_d;
    logic [W-1:0]    qm_q, qm_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rdy_q, rdy_d;
    logic            vld_q, vld_d;
    logic            accept;
    logic            handshake;

    // Next-state, conversion and registered-output logic
    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        qm_d      = qm_q;
        cnt_d     = cnt_q;
        accept    = digit_vld && rdy_q;
        handshake = 1'b0;

        case (state_q)
            ACCUM: begin
                if (accept) begin
                    cnt_d = cnt_q + CW'(1);
                    // Shifts drop the MSB; invalid digits convert as zero
                    case (digit_in)
                        DIG_POS: begin
                            q_d  = W'({q_q, 1'b1});
                            qm_d = W'({q_q, 1'b0});
                        end
                        DIG_NEG: begin
                            q_d  = W'({qm_q, 1'b1});
                            qm_d = W'({qm_q, 1'b0});
                        end
                        default: begin
                            q_d  = W'({q_q, 1'b0});
                            qm_d = W'({qm_q, 1'b1});
                        end
                    endcase
                    if (cnt_q == CW'(NUM_DIGITS - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (result_rdy) begin
                    handshake = 1'b1;
                    state_d   = ACCUM;
                    q_d       = '0;
                    qm_d      = '1;
                    cnt_d     = '0;
                end
            end
            default: state_d = ACCUM;
        endcase

        rdy_d = (state_d == ACCUM);
        vld_d = (state_d == DONE);
    end

    // State registers
    always_ff @(posedge clk or negedge asyn_reset_n) begin
        if (!asyn_reset_n) begin
            state_q <= ACCUM;
            q_q     <= '0;
            qm_q    <= '1;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            qm_q    <= qm_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            vld_q   <= vld_d;
        end
    end

    assign digit_rdy  = rdy_q;
    assign result_vld = vld_q;
    assign result     = q_q;
    assign digit_cnt  = cnt_q;

`ifdef OTF_DIGIT_ERR_EN
    logic err_q, err_d;

    // Sticky invalid-digit flag, cleared by the result handshake
    always_comb begin
        err_d = err_q;
        if (accept && (state_q == ACCUM) && (digit_in == 2'b11)) begin
            err_d = 1'b1;
        end
        if (handshake) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge asyn_reset_n) begin
        if (!asyn_reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_flag = err_q;
`else
    logic unused_hs;
    assign unused_hs = handshake;
    assign err_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_otf_convert_hd.sv
module tb_otf_convert_hd;

    localparam int unsigned N = 8;

    logic         clk;
    logic         asyn_reset_n;
    logic [1:0]   digit_in;
    logic         digit_vld;
    logic         digit_rdy;
    logic [N:0]   result;
    logic         result_vld;
    logic         result_rdy;
    logic         err_flag;
    logic [3:0]   digit_cnt;

    int checks;
    int errors;

    otf_convert_hd #(.NUM_DIGITS(N)) dut (
        .clk          (clk),
        .asyn_reset_n (asyn_reset_n),
        .digit_in     (digit_in),
        .digit_vld    (digit_vld),
        .digit_rdy    (digit_rdy),
        .result       (result),
        .result_vld   (result_vld),
        .result_rdy   (result_rdy),
        .err_flag     (err_flag),
        .digit_cnt    (digit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] digits;   // digit 1 in [15:14] ... digit 8 in [1:0]
        logic [8:0]  exp_res;
        logic        has_inv;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic exp_err(input logic has_inv);
`ifdef OTF_DIGIT_ERR_EN
        return has_inv;
`else
        return 1'b0 & has_inv;
`endif
    endfunction

    // Wait (bounded) for digit_rdy at a negedge
    task automatic wait_rdy(input string name);
        int k;
        k = 0;
        while (!digit_rdy && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!digit_rdy) begin
            checks++;
            errors++;
            $display("FAIL %s: digit_rdy timeout", name);
        end
    endtask

    // Drive one frame, check latency-1 result, optional stall, then handshake
    task automatic run_frame(input string name, input logic [15:0] d,
                             input logic [8:0] exp_res, input logic eerr,
                             input int stall);
        logic [15:0] dv;
        dv = d;
        result_rdy = (stall == 0);
        @(negedge clk);
        wait_rdy(name);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 7) chk({name, " vld_before_last"}, 32'(result_vld), 32'd0);
            digit_in  = dv[15-2*i -: 2];
            digit_vld = 1'b1;
        end
        @(negedge clk);
        digit_vld = 1'b0;
        digit_in  = 2'b00;
        chk({name, " result"}, 32'(result), 32'(exp_res));
        chk({name, " vld"}, 32'(result_vld), 32'd1);
        chk({name, " rdy_done"}, 32'(digit_rdy), 32'd0);
        chk({name, " cnt"}, 32'(digit_cnt), 32'd8);
        chk({name, " err"}, 32'(err_flag), 32'(eerr));
        for (int s = 1; s < stall; s++) begin
            if (s == 2) begin
                digit_in  = 2'b01;
                digit_vld = 1'b1;
            end
            @(negedge clk);
            digit_vld = 1'b0;
            digit_in  = 2'b00;
            chk({name, " stall_vld"}, 32'(result_vld), 32'd1);
            chk({name, " stall_rdy"}, 32'(digit_rdy), 32'd0);
            chk({name, " stall_res"}, 32'(result), 32'(exp_res));
            chk({name, " stall_cnt"}, 32'(digit_cnt), 32'd8);
        end
        result_rdy = 1'b1;
        @(negedge clk);
        result_rdy = 1'b0;
        chk({name, " post_vld"}, 32'(result_vld), 32'd0);
        chk({name, " post_res"}, 32'(result), 32'd0);
        chk({name, " post_cnt"}, 32'(digit_cnt), 32'd0);
        chk({name, " post_err"}, 32'(err_flag), 32'd0);
        chk({name, " post_rdy"}, 32'(digit_rdy), 32'd1);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        asyn_reset_n = 1'b0;
        digit_in     = 2'b00;
        digit_vld    = 1'b0;
        result_rdy   = 1'b0;

        vecs[0] = '{"p_then_0",   16'b01_00_00_00_00_00_00_00, 9'h080, 1'b0};
        vecs[1] = '{"n_p_0",      16'b10_01_00_00_00_00_00_00, 9'h1C0, 1'b0};
        vecs[2] = '{"all_neg",    16'b10_10_10_10_10_10_10_10, 9'h101, 1'b0};
        vecs[3] = '{"all_pos",    16'b01_01_01_01_01_01_01_01, 9'h0FF, 1'b0};
        vecs[4] = '{"invalid2",   16'b01_11_00_00_00_00_00_00, 9'h080, 1'b1};
        vecs[5] = '{"all_zero",   16'b00_00_00_00_00_00_00_00, 9'h000, 1'b0};
        vecs[6] = '{"alt_pn",     16'b01_10_01_10_01_10_01_10, 9'h055, 1'b0};
        vecs[7] = '{"last_pos",   16'b00_00_00_00_00_00_00_01, 9'h001, 1'b0};
        vecs[8] = '{"last_neg",   16'b00_00_00_00_00_00_00_10, 9'h1FF, 1'b0};

        // Reset state
        #12;
        chk("rst result", 32'(result), 32'd0);
        chk("rst vld", 32'(result_vld), 32'd0);
        chk("rst rdy", 32'(digit_rdy), 32'd0);
        chk("rst cnt", 32'(digit_cnt), 32'd0);
        chk("rst err", 32'(err_flag), 32'd0);
        @(negedge clk);
        asyn_reset_n = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", 32'(digit_rdy), 32'd1);

        // digit_in toggling without digit_vld has no effect
        for (int i = 0; i < 4; i++) begin
            digit_in = 2'(i);
            @(negedge clk);
        end
        chk("novld cnt", 32'(digit_cnt), 32'd0);
        chk("novld res", 32'(result), 32'd0);

        // Table-driven frames
        foreach (vecs[i]) begin
            run_frame(vecs[i].name, vecs[i].digits, vecs[i].exp_res,
                      exp_err(vecs[i].has_inv), 0);
        end

        // Output stall with an ignored digit pulse
        run_frame("stall", 16'b10_01_00_00_00_00_00_00, 9'h1C0, 1'b0, 5);

        // Error flag sticky through a stall
        run_frame("inv_stall", 16'b01_11_00_00_00_00_00_00, 9'h080, exp_err(1'b1), 3);

        // Reset mid-frame after 3 digits
        @(negedge clk);
        wait_rdy("midrst");
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            digit_in  = 2'b10;
            digit_vld = 1'b1;
        end
        @(negedge clk);
        digit_vld = 1'b0;
        chk("midrst cnt_before", 32'(digit_cnt), 32'd3);
        chk("midrst res_before", 32'(result), 32'h1F9);
        asyn_reset_n = 1'b0;
        #1;
        chk("midrst res", 32'(result), 32'd0);
        chk("midrst cnt", 32'(digit_cnt), 32'd0);
        chk("midrst rdy", 32'(digit_rdy), 32'd0);
        @(negedge clk);
        asyn_reset_n = 1'b1;
        run_frame("after_rst", 16'b01_00_00_00_00_00_00_00, 9'h080, 1'b0, 0);

        // Reset during DONE drops the pending result
        result_rdy = 1'b0;
        @(negedge clk);
        wait_rdy("donerst");
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            digit_in  = 2'b01;
            digit_vld = 1'b1;
        end
        @(negedge clk);
        digit_vld = 1'b0;
        chk("donerst vld_before", 32'(result_vld), 32'd1);
        asyn_reset_n = 1'b0;
        #1;
        chk("donerst vld", 32'(result_vld), 32'd0);
        chk("donerst res", 32'(result), 32'd0);
        @(negedge clk);
        asyn_reset_n = 1'b1;
        run_frame("after_done_rst", 16'b10_10_10_10_10_10_10_10, 9'h101, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/otf_convert_hd.md
OTF_CONVERT_HD -- requirements
Module: otf_convert_hd

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8; this is the number of signed quotient digits per result frame.
REQ-002 SHALL have port clk, input, 1 bit; the single clock, and all state is updated on its rising edge.
REQ-003 SHALL have port asyn_reset_n, input, 1 bit; reset is asynchronous and active-low.
REQ-004 SHALL have port digit_in, input, 2 bits; the online quotient digit: 2'b00 = 0, 2'b01 = +1, 2'b10 = -1, 2'b11 = invalid.
REQ-005 SHALL have port digit_vld, input, 1 bit; the upstream divider's data_out_vld.
REQ-006 SHALL have port digit_rdy, output, 1 bit; driven back to the upstream divider's data_out_rdy.
REQ-007 SHALL have port result, output, NUM_DIGITS+1 bits; two's-complement quotient, integer value = sum of q_i * 2^(NUM_DIGITS-i), for i = 1..NUM_DIGITS.
REQ-008 SHALL have port result_vld, input-side output, 1 bit, output direction; result-valid flag.
REQ-009 SHALL have port result_rdy, input, 1 bit; downstream ready.
REQ-010 SHALL have port err_flag, output, 1 bit; invalid-digit indicator (see Configuration).
REQ-011 SHALL have port digit_cnt, output, clog2(NUM_DIGITS+1) bits; number of digits accepted in the current frame.

Function
REQ-012 SHALL implement an FSM with two states: ACCUM and DONE.
REQ-013 In ACCUM, digit_rdy SHALL be 1; in DONE, digit_rdy SHALL be 0 and result_vld SHALL be 1.
REQ-014 A digit is accepted only in a cycle where digit_vld and digit_rdy are both 1.
REQ-015 Two internal registers SHALL hold the conversion state: Q and QM, each NUM_DIGITS+1 bits, with QM = Q - 1 at all times.
REQ-016 Register update on acceptance of digit +1: Q <= {Q,1}, QM <= {Q,0}.
REQ-017 Register update on acceptance of digit 0: Q <= {Q,0}, QM <= {QM,1}.
REQ-018 Register update on acceptance of digit -1: Q <= {QM,1}, QM <= {QM,0}.
REQ-019 For all three updates, the left shift SHALL be truncated to NUM_DIGITS+1 bits, and no carry propagation is permitted.
REQ-020 An invalid digit (2'b11) SHALL be converted as digit 0.
REQ-021 Every acceptance SHALL increment digit_cnt by 1.
REQ-022 The acceptance that brings digit_cnt to NUM_DIGITS SHALL move the FSM to DONE on the same clock edge; result_vld is therefore 1 in the cycle after the final digit is accepted (latency 1).
REQ-023 result SHALL equal Q at all times; result is stable throughout DONE.
REQ-024 In DONE, a cycle with result_rdy = 1 SHALL complete the output handshake and, on that same edge, set Q <= 0, QM <= all-ones, digit_cnt <= 0, and the FSM to ACCUM.
REQ-025 Because digit_rdy is 0 in DONE, no digit SHALL be accepted in the handshake cycle; the first digit of the next frame is accepted no earlier than one cycle later.
REQ-026 result_rdy is ignored in ACCUM.
REQ-027 Changes on digit_in while digit_vld is 0 SHALL have no effect.
REQ-028 A result_vld that is held while result_rdy is 0 SHALL stall indefinitely without losing data.
REQ-029 The maximum magnitude, 2^NUM_DIGITS-1, SHALL fit in result without overflow.

Reset
REQ-030 While asyn_reset_n = 0, the block SHALL hold FSM = ACCUM, Q = 0, QM = all-ones, digit_cnt = 0, result = 0, result_vld = 0, and err_flag = 0.
REQ-031 While asyn_reset_n = 0, digit_rdy SHALL be 0; digit_rdy rises to 1 in the first cycle after reset deasserts.
REQ-032 Reset asserted mid-frame or during DONE SHALL discard the partial or pending result immediately, with no output handshake.

Configuration
REQ-033 With macro OTF_DIGIT_ERR_EN defined, accepting digit 2'b11 SHALL set err_flag to 1 from the next cycle onward.
REQ-034 With OTF_DIGIT_ERR_EN defined, err_flag SHALL be sticky through DONE and SHALL clear on the result handshake edge of REQ-024.
REQ-035 Without OTF_DIGIT_ERR_EN, err_flag SHALL be tied to 0 and no error logic SHALL be present; conversion behaviour is identical in both builds.

Verification (NUM_DIGITS = 8)
REQ-036 Digits +1, then 0 x7, with result_rdy = 1 -> result = 9'h080 and result_vld = 1 exactly one cycle after the 8th acceptance, for one cycle.
REQ-037 Digits -1, +1, then 0 x6 -> result = 9'h1C0 (-64).
REQ-038 Digits -1 x8 -> result = 9'h101 (-255); digits +1 x8 -> result = 9'h0FF (255).
REQ-039 Full frame completed with result_rdy = 0 for 5 cycles -> result_vld held for 5 cycles, digit_rdy = 0, result is stable, and a digit_vld pulse during the stall is not accepted.
REQ-040 Reset asserted after 3 digits, then frame +1, 0 x7 -> result = 9'h080 with no residue from the aborted frame.
REQ-041 Digit 2'b11 accepted as the 2nd digit of frame +1, 11, 0 x6 -> result = 9'h080; err_flag = 1 with OTF_DIGIT_ERR_EN (clearing after the handshake) and 0 without it.
